// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and the ALU it drives.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE= 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the FSM's aluop and the R-type funct field to alucontrol.
module mips_aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main FSM for the multicycle MIPS datapath plus the ALU decoder instance.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every output gets a default first, so no path through the case leaves one unassigned (no latch).
    always_comb begin
        state_d  = S_FETCH;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD:  begin iord = 1'b1; state_d = S_MEMWB; end
            S_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
            S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP:   begin pcsrc = 2'b10; pcwrite = 1'b1; end
            default:  state_d = S_FETCH;
        endcase

        // Reset aborts whatever is in flight: FETCH-style selects, no writes.
        if (reset) begin
            aluop    = ALUOP_ADD;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            iord     = 1'b0;
            memtoreg = 1'b0;
            regdst   = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b01;
            pcsrc    = 2'b00;
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    mips_aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed table-driven bench for mips_multicycle_ctrl plus reset-abort and latency sequences.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // en = {pcen, memwrite, irwrite, regwrite}; sel = {iord, memtoreg, regdst, alusrca}
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [3:0] st;
        logic [3:0] en;
        logic [3:0] sel;
        logic [1:0] srcb;
        logic [1:0] pcs;
        logic [2:0] alc;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_AND = 6'b100100;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [5:0] o, logic [5:0] f, logic z, logic [3:0] st,
                                logic [3:0] en, logic [3:0] sel, logic [1:0] srcb,
                                logic [1:0] pcs, logic [2:0] alc);
        vec_t v;
        v.rst = rst; v.op = o; v.fn = f; v.z = z; v.st = st; v.en = en;
        v.sel = sel; v.srcb = srcb; v.pcs = pcs; v.alc = alc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] pack_dut();
        return {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol};
    endfunction

    // Cycles from FETCH back to FETCH; called at a negedge with state == FETCH.
    task automatic run_lat(input string name, input logic [5:0] o, input logic [5:0] f, input int exp);
        int cycles = 0;
        op = o; funct = f; zero = 1'b0;
        do begin
            @(negedge clk);
            cycles++;
        end while (state != 4'd0 && cycles < 20);
        check(name, cycles, exp);
    endtask

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;

        vecs.push_back(mk(1, RT,   0,     0, 0,  4'b0000, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(1, RT,   0,     0, 0,  4'b0000, 4'b0000, 2'b01, 2'b00, 3'b010));
        // lw
        vecs.push_back(mk(0, LW,   0,     0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, LW,   0,     0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, LW,   0,     0, 2,  4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010));
        vecs.push_back(mk(0, LW,   0,     0, 3,  4'b0000, 4'b1000, 2'b00, 2'b00, 3'b010));
        vecs.push_back(mk(0, LW,   0,     0, 4,  4'b0001, 4'b0100, 2'b00, 2'b00, 3'b010));
        // R-type sub
        vecs.push_back(mk(0, RT, F_SUB,   0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, RT, F_SUB,   0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, RT, F_SUB,   0, 6,  4'b0000, 4'b0001, 2'b00, 2'b00, 3'b110));
        vecs.push_back(mk(0, RT, F_SUB,   0, 7,  4'b0001, 4'b0010, 2'b00, 2'b00, 3'b010));
        // R-type slt
        vecs.push_back(mk(0, RT, F_SLT,   0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, RT, F_SLT,   0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, RT, F_SLT,   0, 6,  4'b0000, 4'b0001, 2'b00, 2'b00, 3'b111));
        vecs.push_back(mk(0, RT, F_SLT,   0, 7,  4'b0001, 4'b0010, 2'b00, 2'b00, 3'b010));
        // beq taken; zero is ignored in DECODE
        vecs.push_back(mk(0, BEQ,  0,     1, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, BEQ,  0,     1, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, BEQ,  0,     1, 8,  4'b1000, 4'b0001, 2'b00, 2'b01, 3'b110));
        // beq not taken
        vecs.push_back(mk(0, BEQ,  0,     0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, BEQ,  0,     0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, BEQ,  0,     0, 8,  4'b0000, 4'b0001, 2'b00, 2'b01, 3'b110));
        // j
        vecs.push_back(mk(0, JMP,  0,     0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, JMP,  0,     0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, JMP,  0,     0, 11, 4'b1000, 4'b0000, 2'b00, 2'b10, 3'b010));
        // unknown opcode: nop
        vecs.push_back(mk(0, BAD,  0,     0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, BAD,  0,     0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        // addi
        vecs.push_back(mk(0, ADDI, 0,     0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, ADDI, 0,     0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, ADDI, 0,     0, 9,  4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010));
        vecs.push_back(mk(0, ADDI, 0,     0, 10, 4'b0001, 4'b0000, 2'b00, 2'b00, 3'b010));
        // R-type and
        vecs.push_back(mk(0, RT, F_AND,   0, 0,  4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        vecs.push_back(mk(0, RT, F_AND,   0, 1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        vecs.push_back(mk(0, RT, F_AND,   0, 6,  4'b0000, 4'b0001, 2'b00, 2'b00, 3'b000));
        vecs.push_back(mk(0, RT, F_AND,   0, 7,  4'b0001, 4'b0010, 2'b00, 2'b00, 3'b010));

        @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z;
            #1;
            check($sformatf("vec%0d", i), {13'd0, pack_dut()},
                  {13'd0, vecs[i].st, vecs[i].en, vecs[i].sel, vecs[i].srcb, vecs[i].pcs, vecs[i].alc});
        end

        // sw aborted by reset while in MEMADR
        @(negedge clk); op = SW; #1;
        check("sw_fetch_state", state, 0);
        @(negedge clk); #1;
        check("sw_decode_state", state, 1);
        @(negedge clk); #1;
        check("sw_memadr_state", state, 2);
        check("sw_memadr_memwrite", memwrite, 0);
        reset = 1'b1; #1;
        check("abort_forced_alusrcb", {alusrca, alusrcb, pcen}, {1'b0, 2'b01, 1'b0});
        @(negedge clk); #1;
        check("abort_state", state, 0);
        check("abort_enables", {pcen, memwrite, irwrite, regwrite}, 4'b0000);
        reset = 1'b0; #1;
        check("resume_fetch", {pcen, irwrite, alusrcb, alucontrol}, {1'b1, 1'b1, 2'b01, 3'b010});
        @(negedge clk); #1;
        check("resume_decode", state, 1);
        @(negedge clk); #1;
        check("resume_memadr", state, 2);
        @(negedge clk); #1;
        check("sw_memwr", {state, memwrite, iord}, {4'd5, 1'b1, 1'b1});
        @(negedge clk); #1;
        check("sw_back_to_fetch", state, 0);

        run_lat("lat_lw",   LW,   6'd0,  5);
        run_lat("lat_sw",   SW,   6'd0,  4);
        run_lat("lat_r",    RT,   F_SUB, 4);
        run_lat("lat_addi", ADDI, 6'd0,  4);
        run_lat("lat_beq",  BEQ,  6'd0,  3);
        run_lat("lat_j",    JMP,  6'd0,  3);
        run_lat("lat_bad",  BAD,  6'd0,  2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
